// File: rtl/udma_ch_arb_pkg.sv
// Shared types and size codes for the uDMA channel arbiter.
package udma_ch_arb_pkg;

    localparam logic [1:0] UDMA_SIZE_8  = 2'b00;
    localparam logic [1:0] UDMA_SIZE_16 = 2'b01;
    localparam logic [1:0] UDMA_SIZE_32 = 2'b10;

    // Beat fields are sized for the largest supported configuration.
    localparam int UDMA_MAX_AW     = 32;
    localparam int UDMA_MAX_SID_W  = 8;
    localparam int UDMA_MAX_CHID_W = 5;

    typedef struct packed {
        logic [UDMA_MAX_AW-1:0]     addr;
        logic [1:0]                 datasize;
        logic [UDMA_MAX_SID_W-1:0]  stream_id;
        logic [UDMA_MAX_CHID_W-1:0] ch_id;
    } udma_beat_t;

endpackage

// File: rtl/udma_rr_pick.sv
// Find-first-set starting one past a pointer, wrapping modulo N.
module udma_rr_pick #(
    parameter int N  = 8,
    parameter int LW = 3
) (
    input  logic [N-1:0]  req_i,
    input  logic [LW-1:0] ptr_i,
    output logic          valid_o,
    output logic [LW-1:0] idx_o,
    output logic [N-1:0]  onehot_o
);

    logic [LW-1:0] j;

    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        j        = ptr_i;
        for (int i = 0; i < N; i++) begin
            j = (j == LW'(N - 1)) ? '0 : j + LW'(1);
            if (req_i[j] && !valid_o) begin
                valid_o = 1'b1;
                idx_o   = j;
            end
        end
        if (valid_o) begin
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/udma_ch_arbiter.sv
// Round-robin arbiter sharing the uDMA L2 request port among channels.
// Optional high-priority mask enabled by UDMA_CH_ARB_PRIO_EN.
module udma_ch_arbiter
    import udma_ch_arb_pkg::*;
#(
    parameter  int N_CH            = 8,
    parameter  int L2_AWIDTH_NOAL  = 18,
    parameter  int STREAM_ID_WIDTH = 3,
    localparam int LOG_N_CH        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                                      clk_i,
    input  logic                                      rstn_i,
    input  logic                                      clr_i,
`ifdef UDMA_CH_ARB_PRIO_EN
    input  logic [N_CH-1:0]                           cfg_prio_i,
`endif
    input  logic [N_CH-1:0]                           ch_req_i,
    input  logic [N_CH-1:0][L2_AWIDTH_NOAL-1:0]       ch_addr_i,
    input  logic [N_CH-1:0][1:0]                      ch_datasize_i,
    input  logic [N_CH-1:0][STREAM_ID_WIDTH-1:0]      ch_stream_id_i,
    output logic [N_CH-1:0]                           ch_gnt_o,
    output logic                                      not_stall_o,
    output logic                                      out_valid_o,
    input  logic                                      out_ready_i,
    output logic [L2_AWIDTH_NOAL-1:0]                 out_addr_o,
    output logic [1:0]                                out_datasize_o,
    output logic [LOG_N_CH-1:0]                       out_ch_id_o,
    output logic [STREAM_ID_WIDTH-1:0]                out_stream_id_o
);

    logic [N_CH-1:0]     cand;
    logic                win_valid;
    logic [LOG_N_CH-1:0] win_idx;
    logic [N_CH-1:0]     win_oh;
    logic                fire;

    logic                valid_q, valid_d;
    logic [LOG_N_CH-1:0] last_q, last_d;
    udma_beat_t          beat_q, beat_d;
    logic                unused_beat;

`ifdef UDMA_CH_ARB_PRIO_EN
    logic [N_CH-1:0] prio_req;
    assign prio_req = ch_req_i & cfg_prio_i;
    assign cand     = (|prio_req) ? prio_req : ch_req_i;
`else
    assign cand = ch_req_i;
`endif

    udma_rr_pick #(
        .N  (N_CH),
        .LW (LOG_N_CH)
    ) u_pick (
        .req_i    (cand),
        .ptr_i    (last_q),
        .valid_o  (win_valid),
        .idx_o    (win_idx),
        .onehot_o (win_oh)
    );

    assign not_stall_o = !valid_q || out_ready_i;
    assign fire        = win_valid && not_stall_o && !clr_i;
    assign ch_gnt_o    = fire ? win_oh : '0;

    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        beat_d  = beat_q;
        if (clr_i) begin
            valid_d = 1'b0;
            last_d  = LOG_N_CH'(N_CH - 1);
        end else if (fire) begin
            valid_d          = 1'b1;
            last_d           = win_idx;
            beat_d.addr      = UDMA_MAX_AW'(ch_addr_i[win_idx]);
            beat_d.datasize  = ch_datasize_i[win_idx];
            beat_d.stream_id = UDMA_MAX_SID_W'(ch_stream_id_i[win_idx]);
            beat_d.ch_id     = UDMA_MAX_CHID_W'(win_idx);
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            last_q  <= LOG_N_CH'(N_CH - 1);
            beat_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    // High beat bits are constant zero for narrow configurations.
    assign unused_beat = ^beat_q;

    assign out_valid_o     = valid_q;
    assign out_addr_o      = beat_q.addr[L2_AWIDTH_NOAL-1:0];
    assign out_datasize_o  = beat_q.datasize;
    assign out_ch_id_o     = beat_q.ch_id[LOG_N_CH-1:0];
    assign out_stream_id_o = beat_q.stream_id[STREAM_ID_WIDTH-1:0];

endmodule

// File: tb/tb_udma_ch_arbiter.sv
// Directed bench for udma_ch_arbiter (N_CH = 8).
module tb_udma_ch_arbiter;

    logic             clk;
    logic             rstn;
    logic             clr;
    logic [7:0]       cfg_prio;
    logic [7:0]       req;
    logic [7:0][17:0] addr;
    logic [7:0][1:0]  dsz;
    logic [7:0][2:0]  sid;
    logic [7:0]       gnt;
    logic             not_stall;
    logic             ovalid;
    logic             oready;
    logic [17:0]      oaddr;
    logic [1:0]       odsz;
    logic [2:0]       och;
    logic [2:0]       osid;

    int checks = 0;
    int errors = 0;

    udma_ch_arbiter dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .clr_i           (clr),
`ifdef UDMA_CH_ARB_PRIO_EN
        .cfg_prio_i      (cfg_prio),
`endif
        .ch_req_i        (req),
        .ch_addr_i       (addr),
        .ch_datasize_i   (dsz),
        .ch_stream_id_i  (sid),
        .ch_gnt_o        (gnt),
        .not_stall_o     (not_stall),
        .out_valid_o     (ovalid),
        .out_ready_i     (oready),
        .out_addr_o      (oaddr),
        .out_datasize_o  (odsz),
        .out_ch_id_o     (och),
        .out_stream_id_o (osid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected beat for channel n: address 0x1000+16n, size n%3 (ch5 uses 11), sid n.
    task automatic chk_beat(input string tag, input int n);
        logic [17:0] ea;
        logic [1:0]  ed;
        ea = 18'h1000 + 18'(n * 16);
        ed = (n == 5) ? 2'b11 : 2'(n % 3);
        chk({tag, "_valid"}, 32'(ovalid), 32'd1);
        chk({tag, "_ch"}, 32'(och), 32'(n));
        chk({tag, "_addr"}, 32'(oaddr), 32'(ea));
        chk({tag, "_dsz"}, 32'(odsz), 32'(ed));
        chk({tag, "_sid"}, 32'(osid), 32'(n));
    endtask

    initial begin
        rstn     = 1'b0;
        clr      = 1'b0;
        cfg_prio = 8'h00;
        req      = 8'h00;
        oready   = 1'b1;
        for (int n = 0; n < 8; n++) begin
            addr[n] = 18'h1000 + 18'(n * 16);
            dsz[n]  = (n == 5) ? 2'b11 : 2'(n % 3);
            sid[n]  = 3'(n);
        end

        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_nstall", 32'(not_stall), 32'h1);
        chk("rst_valid", 32'(ovalid), 32'h0);
        chk("rst_addr", 32'(oaddr), 32'h0);
        chk("rst_dsz", 32'(odsz), 32'h0);
        chk("rst_ch", 32'(och), 32'h0);
        chk("rst_sid", 32'(osid), 32'h0);

        // All channels requesting: strict rotation from channel 0.
        req = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("rr_gnt", 32'(gnt), 32'(8'h01 << (k % 8)));
            @(negedge clk);
            chk_beat("rr_beat", k % 8);
        end
        req = 8'h00;
        @(negedge clk);
        chk("drain_valid", 32'(ovalid), 32'h0);

        // Backpressure: ch2 beat held, ch5 granted on release.
        req    = 8'h24;
        oready = 1'b0;
        #1;
        chk("bp_gnt2", 32'(gnt), 32'h04);
        @(negedge clk);
        chk_beat("bp_hold1", 2);
        #1;
        chk("bp_gnt_stall", 32'(gnt), 32'h0);
        chk("bp_nstall", 32'(not_stall), 32'h0);
        @(negedge clk);
        chk_beat("bp_hold2", 2);
        oready = 1'b1;
        #1;
        chk("bp_gnt5", 32'(gnt), 32'h20);
        chk("bp_nstall_rel", 32'(not_stall), 32'h1);
        @(negedge clk);
        chk_beat("bp_beat5", 5);
        req = 8'h00;
        @(negedge clk);
        chk("bp_drain", 32'(ovalid), 32'h0);

        // Move pointer to 6, then wrap 7 -> 0.
        req = 8'h40;
        #1;
        chk("wrap_gnt6", 32'(gnt), 32'h40);
        @(negedge clk);
        req = 8'h81;
        #1;
        chk("wrap_gnt7", 32'(gnt), 32'h80);
        @(negedge clk);
        chk_beat("wrap_beat7", 7);
        #1;
        chk("wrap_gnt0", 32'(gnt), 32'h01);
        @(negedge clk);
        chk_beat("wrap_beat0", 0);
        req = 8'h00;
        @(negedge clk);

        // Clear drops the held beat and resets the pointer.
        req = 8'h10;
        #1;
        chk("clr_pre_gnt", 32'(gnt), 32'h10);
        @(negedge clk);
        chk_beat("clr_pre_beat", 4);
        clr = 1'b1;
        #1;
        chk("clr_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        chk("clr_valid", 32'(ovalid), 32'h0);
        clr = 1'b0;
        #1;
        chk("clr_post_gnt", 32'(gnt), 32'h10);
        @(negedge clk);
        chk_beat("clr_post_beat", 4);
        req = 8'h30;
        #1;
        chk("clr_ptr4", 32'(gnt), 32'h20);
        @(negedge clk);

        // Lone requester is granted every cycle.
        req = 8'h08;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("lone_gnt", 32'(gnt), 32'h08);
            @(negedge clk);
            chk_beat("lone_beat", 3);
        end

`ifdef UDMA_CH_ARB_PRIO_EN
        cfg_prio = 8'h08;
        req      = 8'h0F;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("prio_gnt", 32'(gnt), 32'h08);
            @(negedge clk);
        end
        req = 8'h07;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("prio_rr_gnt", 32'(gnt), 32'(8'h01 << k));
            @(negedge clk);
        end
`endif
        req = 8'h00;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udma_ch_arbiter.md
# udma_ch_arbiter

Round-robin arbiter that shares the single uDMA L2 request port between N_CH channel address generators. It grants one requesting channel per cycle and drives each channel's grant and not-stall inputs. The granted channel's address, data size and stream ID are captured into a one-entry output register with a valid/ready handshake toward the L2 request path. It sits between the per-channel address generators and the L2 transaction interface.

## Interface
- N_CH, 8: number of channels, 2..32; LOG_N_CH = max(1, $clog2(N_CH)) is derived.
- L2_AWIDTH_NOAL, 18: address width.
- STREAM_ID_WIDTH, 3: stream ID width.
- clk_i  in  1  clock; all state is on the rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- clr_i  in  1  synchronous flush of the output register and the RR pointer.
- ch_req_i  in  N_CH  channel n has a beat pending; comes from the channel enable.
- ch_addr_i  in  N_CH×L2_AWIDTH_NOAL  per-channel current address.
- ch_datasize_i  in  N_CH×2  per-channel size code: 00 = 1 B, 01 = 2 B, 10 = 4 B.
- ch_stream_id_i  in  N_CH×STREAM_ID_WIDTH  per-channel stream ID.
- ch_gnt_o  out  N_CH  one-hot grant; drives the channel grant input.
- not_stall_o  out  1  output slot can accept a beat; drives the shared not-stall input.
- out_valid_o  out  1  output register holds a beat.
- out_ready_i  in  1  downstream accepts the beat.
- out_addr_o  out  L2_AWIDTH_NOAL  registered address.
- out_datasize_o  out  2  registered size code.
- out_ch_id_o  out  LOG_N_CH  index of the granted channel.
- out_stream_id_o  out  STREAM_ID_WIDTH  registered stream ID.
- cfg_prio_i  in  N_CH  high-priority channel mask; present only when UDMA_CH_ARB_PRIO_EN is defined.

## Operation
- not_stall_o = !out_valid_o || out_ready_i.
- Arbitration is combinational.
  - Candidate set: ch_req_i.
  - Winner: the first set bit at index r_last+1 upward, wrapping modulo N_CH.
  - ch_gnt_o = onehot(winner) when the candidate set is non-empty, not_stall_o = 1 and clr_i = 0; otherwise 0.
- Fire = |ch_gnt_o. On fire:
  - r_last <= winner.
  - The output register loads addr, datasize and stream_id of the winner; out_ch_id_o <= winner.
  - out_valid_o <= 1.
- No fire while out_valid_o && out_ready_i: out_valid_o <= 0.
- Stall (out_valid_o && !out_ready_i): no grant, r_last holds, output register holds.
- clr_i has priority over everything: out_valid_o <= 0, r_last <= N_CH-1, no grant in that cycle. A beat held in the output register is dropped.
- ch_datasize_i = 11 is forwarded unchanged; no checking is done.
- A request that deasserts before it is granted is simply not served. No state is kept per requester.

## Timing
- Reset values:
  - out_valid_o = 0; out_addr_o, out_datasize_o, out_ch_id_o, out_stream_id_o = 0.
  - r_last = N_CH-1, so channel 0 wins first.
  - ch_gnt_o = 0 until a request arrives; not_stall_o = 1.
- Grant is issued in the same cycle as the request, zero latency.
- The payload is on the outputs with out_valid_o = 1 in the cycle after the grant.
- Throughput is 1 beat/cycle while out_ready_i = 1. No bubble between consecutive beats.
- out_valid_o and the payload are stable while out_valid_o && !out_ready_i.
- Pointer wrap: the winner after index N_CH-1 is searched from index 0.
- A lone requester is granted every cycle.

## Configuration
- UDMA_CH_ARB_PRIO_EN defined:
  - Port cfg_prio_i exists.
  - If (ch_req_i & cfg_prio_i) != 0, the candidate set is ch_req_i & cfg_prio_i; otherwise it is ch_req_i.
  - The same r_last pointer is used in both cases.
- UDMA_CH_ARB_PRIO_EN undefined: port absent, pure round-robin, no extra logic.

## Structure
- Package udma_ch_arb_pkg:
  - typedef udma_beat_t, a struct of addr, datasize, stream_id, ch_id.
  - Size-code localparams UDMA_SIZE_8/16/32.
- Sub-module udma_rr_pick: combinational find-first-set starting after a pointer, with wrap.
  - Inputs: req vector, pointer. Outputs: valid, index, onehot.
  - Reusable for the TX/RX split later.

## Test plan
- Reset release, ch_req_i = 0 -> ch_gnt_o = 0, not_stall_o = 1, out_valid_o = 0, all outputs 0.
- N_CH = 8, ch_req_i = FF, out_ready_i = 1 for 10 cycles -> grants 0,1,…,7,0,1. out_ch_id_o lags by one cycle with the matching ch_addr_i.
- ch_req_i = 0x24, out_ready_i held 0 after the first beat -> channel 2 is granted once, then ch_gnt_o = 0 and the payload holds. On release, channel 5 is granted in the same cycle and the channel-2 beat completes.
- r_last = 6, ch_req_i = 0x81 -> channel 7, then channel 0 (wrap).
- clr_i pulsed while out_valid_o = 1 and ch_req_i = 0x10 -> out_valid_o = 0 next cycle and no grant during clr_i. The next grant goes to channel 4 with r_last = 4 afterwards.
- With UDMA_CH_ARB_PRIO_EN, cfg_prio_i = 0x08, ch_req_i = 0x0F -> channel 3 is granted every cycle. After ch_req_i = 0x07, round-robin resumes from index 4 -> 0,1,2.
